// File: rtl/control_sequencer_module_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, T-states and
// the bit layout of the control word produced by the microcode decode.
package control_sequencer_module_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  localparam int CW_PC_OE    = 0;
  localparam int CW_PC_STEP  = 1;
  localparam int CW_PC_IE    = 2;
  localparam int CW_MAR_IE   = 3;
  localparam int CW_RAM_OE   = 4;
  localparam int CW_RAM_IE   = 5;
  localparam int CW_IR_IE    = 6;
  localparam int CW_IR_OE    = 7;
  localparam int CW_A_IE     = 8;
  localparam int CW_A_OE     = 9;
  localparam int CW_B_IE     = 10;
  localparam int CW_ALU_OE   = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_FLAGS_IE = 13;
  localparam int CW_OUT_IE   = 14;
  localparam int CW_W        = 15;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t cw_bit(input int idx);
    ctrl_word_t w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer_module_decode.sv
// Combinational microcode ROM: maps (opcode, T-state, flags) to the control
// word for this cycle plus a flag marking the instruction's final step.
module microcode_decode_module
  import control_sequencer_module_pkg::*;
#(
  parameter int TSTATE_W = 3,
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [TSTATE_W-1:0] i_tstate,
  input  logic                i_carry_flag,
  input  logic                i_zero_flag,
  output ctrl_word_t          o_ctrl,
  output logic                o_last
);

  always_comb begin
    o_ctrl = '0;
    o_last = 1'b0;
    case (i_tstate)
      T0: o_ctrl = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_IE);
      T1: o_ctrl = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_IE) | cw_bit(CW_PC_STEP);
      T2: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_IE);
            o_last = 1'b0;
          end
          OP_LDI: o_ctrl = cw_bit(CW_IR_OE) | cw_bit(CW_A_IE);
          OP_JMP: o_ctrl = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
          OP_JC:  if (i_carry_flag) o_ctrl = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
          OP_JZ:  if (i_zero_flag)  o_ctrl = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
          OP_OUT: o_ctrl = cw_bit(CW_A_OE) | cw_bit(CW_OUT_IE);
          default: o_ctrl = '0;
        endcase
      end
      T3: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA: o_ctrl = cw_bit(CW_RAM_OE) | cw_bit(CW_A_IE);
          OP_STA: o_ctrl = cw_bit(CW_A_OE) | cw_bit(CW_RAM_IE);
          OP_ADD: begin
            o_ctrl = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IE);
            o_last = 1'b0;
          end
          OP_SUB: begin
            o_ctrl = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IE) | cw_bit(CW_ALU_SUB);
            o_last = 1'b0;
          end
          default: o_ctrl = '0;
        endcase
      end
      T4: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_ADD: o_ctrl = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IE) | cw_bit(CW_FLAGS_IE);
          OP_SUB: o_ctrl = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IE) | cw_bit(CW_FLAGS_IE)
                         | cw_bit(CW_ALU_SUB);
          default: o_ctrl = '0;
        endcase
      end
      // Unreachable counter values end the instruction so the counter recovers.
      default: o_last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer_module.sv
// Fetch/execute sequencer: T-state counter, halt latch and reset gating
// around the microcode decode that drives every bus strobe.
module control_sequencer_module
  import control_sequencer_module_pkg::*;
#(
  parameter int TSTATE_W = 3,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                pc_oe,
  output logic                pc_step,
  output logic                pc_ie,
  output logic                mar_ie,
  output logic                ram_oe,
  output logic                ram_ie,
  output logic                ir_ie,
  output logic                ir_oe,
  output logic                a_ie,
  output logic                a_oe,
  output logic                b_ie,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                flags_ie,
  output logic                out_ie,
  output logic                halted,
  output logic [TSTATE_W-1:0] tstate
);

  logic [TSTATE_W-1:0] r_tstate;
  logic [TSTATE_W-1:0] w_tstateNext;
  logic                r_halted;
  logic                w_haltedNext;
  ctrl_word_t          w_ctrl;
  ctrl_word_t          w_ctrlGated;
  logic                w_last;

  microcode_decode_module #(
    .TSTATE_W(TSTATE_W),
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .i_opcode    (opcode),
    .i_tstate    (r_tstate),
    .i_carry_flag(carry_flag),
    .i_zero_flag (zero_flag),
    .o_ctrl      (w_ctrl),
    .o_last      (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tstate <= '0;
      r_halted <= 1'b0;
    end else begin
      r_tstate <= w_tstateNext;
      r_halted <= w_haltedNext;
    end
  end

  always_comb begin
    w_tstateNext = r_tstate;
    w_haltedNext = r_halted;
    if (!r_halted) begin
      if (w_last) begin
        w_tstateNext = '0;
        if (r_tstate == TSTATE_W'(T2) && opcode == OP_HLT) w_haltedNext = 1'b1;
      end else begin
        w_tstateNext = r_tstate + TSTATE_W'(1);
      end
    end
  end

  // Strobes are gated by the reset pin itself so nothing fires while it is held.
  always_comb begin
    w_ctrlGated = (rst && !r_halted) ? w_ctrl : '0;
    pc_oe    = w_ctrlGated[CW_PC_OE];
    pc_step  = w_ctrlGated[CW_PC_STEP];
    pc_ie    = w_ctrlGated[CW_PC_IE];
    mar_ie   = w_ctrlGated[CW_MAR_IE];
    ram_oe   = w_ctrlGated[CW_RAM_OE];
    ram_ie   = w_ctrlGated[CW_RAM_IE];
    ir_ie    = w_ctrlGated[CW_IR_IE];
    ir_oe    = w_ctrlGated[CW_IR_OE];
    a_ie     = w_ctrlGated[CW_A_IE];
    a_oe     = w_ctrlGated[CW_A_OE];
    b_ie     = w_ctrlGated[CW_B_IE];
    alu_oe   = w_ctrlGated[CW_ALU_OE];
    alu_sub  = w_ctrlGated[CW_ALU_SUB];
    flags_ie = w_ctrlGated[CW_FLAGS_IE];
    out_ie   = w_ctrlGated[CW_OUT_IE];
    halted   = r_halted;
    tstate   = r_tstate;
  end

  busDriverExclusive: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}));
  pcStepLoadExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(pc_step && pc_ie));
  tstateInRange: assert property (@(posedge clk) disable iff (!rst)
    r_tstate <= TSTATE_W'(T4));

endmodule

// File: tb/tb_control_sequencer_module.sv
// Self-checking bench: directed instruction runs with literal expectations,
// then random opcodes, flags and mid-instruction resets against a step model.
module tb_control_sequencer_module;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h5;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
  logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, halted;
  logic [2:0] tstate;

  int compared = 0;
  int failed = 0;

  // Bench-local strobe ordering, independent of the design's control word.
  localparam logic [14:0] S_PC_OE    = 15'h4000;
  localparam logic [14:0] S_PC_STEP  = 15'h2000;
  localparam logic [14:0] S_PC_IE    = 15'h1000;
  localparam logic [14:0] S_MAR_IE   = 15'h0800;
  localparam logic [14:0] S_RAM_OE   = 15'h0400;
  localparam logic [14:0] S_RAM_IE   = 15'h0200;
  localparam logic [14:0] S_IR_IE    = 15'h0100;
  localparam logic [14:0] S_IR_OE    = 15'h0080;
  localparam logic [14:0] S_A_IE     = 15'h0040;
  localparam logic [14:0] S_A_OE     = 15'h0020;
  localparam logic [14:0] S_B_IE     = 15'h0010;
  localparam logic [14:0] S_ALU_OE   = 15'h0008;
  localparam logic [14:0] S_ALU_SUB  = 15'h0004;
  localparam logic [14:0] S_FLAGS_IE = 15'h0002;
  localparam logic [14:0] S_OUT_IE   = 15'h0001;

  logic [14:0] actWord;
  assign actWord = {pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
                    a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie};

  control_sequencer_module dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_oe(pc_oe), .pc_step(pc_step), .pc_ie(pc_ie), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
    .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .flags_ie(flags_ie), .out_ie(out_ie), .halted(halted), .tstate(tstate)
  );

  always #5 clk = ~clk;

  function automatic int instrLen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] expWord(input logic [3:0] op, input int pos,
                                          input logic c, input logic z);
    if (pos == 0) return S_PC_OE | S_MAR_IE;
    if (pos == 1) return S_RAM_OE | S_IR_IE | S_PC_STEP;
    case (op)
      4'h1: return (pos == 2) ? (S_IR_OE | S_MAR_IE) : (S_RAM_OE | S_A_IE);
      4'h2: return (pos == 2) ? (S_IR_OE | S_MAR_IE) :
                   (pos == 3) ? (S_RAM_OE | S_B_IE) : (S_ALU_OE | S_A_IE | S_FLAGS_IE);
      4'h3: return (pos == 2) ? (S_IR_OE | S_MAR_IE) :
                   (pos == 3) ? (S_RAM_OE | S_B_IE | S_ALU_SUB) :
                                (S_ALU_OE | S_A_IE | S_FLAGS_IE | S_ALU_SUB);
      4'h4: return (pos == 2) ? (S_IR_OE | S_MAR_IE) : (S_A_OE | S_RAM_IE);
      4'h5: return S_IR_OE | S_A_IE;
      4'h6: return S_IR_OE | S_PC_IE;
      4'h7: return c ? (S_IR_OE | S_PC_IE) : 15'h0;
      4'h8: return z ? (S_IR_OE | S_PC_IE) : 15'h0;
      4'hE: return S_A_OE | S_OUT_IE;
      default: return 15'h0;
    endcase
  endfunction

  // Model: position within the current instruction and the halt latch.
  int   mPos = 0;
  logic mHalted = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPos    <= 0;
      mHalted <= 1'b0;
    end else if (!mHalted) begin
      if (mPos + 1 >= instrLen(opcode)) begin
        mPos <= 0;
        if (opcode == 4'hF) mHalted <= 1'b1;
      end else begin
        mPos <= mPos + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [14:0] e;
    e = (!rst || mHalted) ? 15'h0 : expWord(opcode, mPos, carry_flag, zero_flag);
    checkOutput("strobes", {17'h0, actWord}, {17'h0, e});
    checkOutput("tstate", {29'h0, tstate}, mPos);
    checkOutput("halted", {31'h0, halted}, {31'h0, mHalted});
    checkOutput("tstate_le4", {31'h0, (tstate <= 3'd4)}, 32'd1);
  end

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (mPos == 0 && !mHalted) opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_strobes", {17'h0, actWord}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("first_t0", {17'h0, actWord}, {17'h0, S_PC_OE | S_MAR_IE});
    checkOutput("first_tstate", {29'h0, tstate}, 32'd0);

    @(negedge clk);
    checkOutput("ldi_t1", {17'h0, actWord}, 32'h2500);
    @(negedge clk);
    checkOutput("ldi_t2", {17'h0, actWord}, 32'h00C0);
    @(negedge clk);
    checkOutput("ldi_done", {29'h0, tstate}, 32'd0);
    #1 opcode = 4'h3;

    repeat (4) @(negedge clk);
    checkOutput("sub_t4", {17'h0, actWord}, 32'h004E);
    @(negedge clk);
    checkOutput("sub_done", {29'h0, tstate}, 32'd0);
    #1 opcode = 4'h7;
    carry_flag = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("jc_nc_t2", {17'h0, actWord}, 32'h0);
    @(negedge clk);
    checkOutput("jc_nc_done", {29'h0, tstate}, 32'd0);
    #1 carry_flag = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("jc_c_t2", {17'h0, actWord}, 32'h1080);
    @(negedge clk);
    checkOutput("jc_c_done", {29'h0, tstate}, 32'd0);
    #1 opcode = 4'hF;

    repeat (2) @(negedge clk);
    checkOutput("hlt_t2_not_halted", {31'h0, halted}, 32'd0);
    @(negedge clk);
    checkOutput("hlt_halted", {31'h0, halted}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("hlt_idle_strobes", {17'h0, actWord}, 32'h0);
    checkOutput("hlt_idle_tstate", {29'h0, tstate}, 32'd0);
    #1 rst = 1'b0;
    #1 checkOutput("hlt_cleared", {31'h0, halted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus(1000);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
